// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Brief    : Shared constants and scoreboard entry type for the forwarding
//            and hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Forward select value meaning "use the register-file read data"
    localparam int FWD_RF     = 0;

    // First pipeline register that holds the result for each producer class
    localparam int AVAIL_ALU  = 1;
    localparam int AVAIL_LOAD = 2;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances zero-extend into them. RA_W must not exceed SB_RA_W_MAX and
    // DEPTH must not exceed 2**SB_AVAIL_W_MAX.
    localparam int SB_RA_W_MAX    = 8;
    localparam int SB_AVAIL_W_MAX = 4;

    typedef struct packed {
        logic                      wen;
        logic [SB_RA_W_MAX-1:0]    rd;
        logic [SB_AVAIL_W_MAX-1:0] avail;
    } sb_entry_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fwd_src_resolve.sv
`default_nettype none
// ============================================================================
// Module   : fwd_src_resolve
// Brief    : Resolves one ID-stage source operand against the scoreboard:
//            youngest-producer match, forward select, WB bypass or stall.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_src_resolve
    import pipe_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int SW    = $clog2(DEPTH)
) (
    input  logic [RA_W-1:0]        i_rs,
    input  logic                   i_rs_used,
    input  sb_entry_t [DEPTH-1:0]  i_entries,
    output logic                   o_stall,
    output logic                   o_wb_bypass,
    output logic [SW-1:0]          o_fwd_sel
);

    logic w_found;
    int   w_k;

    // Youngest matching producer decides the operand source; x0 never matches
    always_comb begin
        o_stall     = 1'b0;
        o_wb_bypass = 1'b0;
        o_fwd_sel   = SW'(FWD_RF);
        w_found     = 1'b0;
        w_k         = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!w_found && i_entries[k].wen &&
                (i_entries[k].rd == SB_RA_W_MAX'(i_rs))) begin
                w_found = 1'b1;
                w_k     = k;
            end
        end
        if (i_rs_used && (i_rs != '0) && w_found) begin
            if (w_k == DEPTH - 1) begin
                // Producer is writing back this cycle: take WB data in ID
                o_wb_bypass = 1'b1;
            end else if ((w_k + 1) >= int'(i_entries[w_k].avail)) begin
                // Result will sit in pipeline register w_k+1 next cycle
                o_fwd_sel = SW'(w_k + 1);
            end else begin
                o_stall = 1'b1;
            end
        end
    end

endmodule : fwd_src_resolve
`default_nettype wire

// File: rtl/fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_scoreboard
// Brief    : Shift-register scoreboard of in-flight register writes with
//            per-source forwarding selects, load-use stall, ID-stage WB
//            bypass and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int RA_W    = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SW      = $clog2(DEPTH),
    parameter int CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [NUM_SRC*RA_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]      id_rs_used,
    input  logic [RA_W-1:0]         id_rd,
    input  logic                    id_reg_write,
    input  logic [SW-1:0]           id_avail,
    input  logic                    pipe_freeze,
    input  logic                    flush,
    output logic                    hazard_stall,
    output logic [NUM_SRC-1:0]      id_wb_bypass,
    output logic [NUM_SRC*SW-1:0]   ex_fwd_sel,
    output logic [CNT_W-1:0]        stall_cnt
);

    sb_entry_t [DEPTH-1:0]   r_sb;
    logic [NUM_SRC*SW-1:0]   r_ex_fwd_sel;
    logic [CNT_W-1:0]        r_stall_cnt;

    sb_entry_t               w_id_entry;
    logic [NUM_SRC-1:0]      w_src_stall;
    logic [NUM_SRC*SW-1:0]   w_fwd_sel;
    logic                    w_insert;

    // Build the entry the ID instruction would occupy; x0 writes are dropped
    always_comb begin
        w_id_entry       = '0;
        w_id_entry.wen   = id_valid && id_reg_write && (id_rd != '0);
        w_id_entry.rd    = SB_RA_W_MAX'(id_rd);
        w_id_entry.avail = SB_AVAIL_W_MAX'(id_avail);
    end

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_resolve #(
                .RA_W  (RA_W),
                .DEPTH (DEPTH),
                .SW    (SW)
            ) u_resolve (
                .i_rs        (id_rs[gi*RA_W +: RA_W]),
                .i_rs_used   (id_rs_used[gi]),
                .i_entries   (r_sb),
                .o_stall     (w_src_stall[gi]),
                .o_wb_bypass (id_wb_bypass[gi]),
                .o_fwd_sel   (w_fwd_sel[gi*SW +: SW])
            );
        end
    endgenerate

    // Flush kills the ID instruction, so it can never also be stalled
    always_comb begin
        hazard_stall = id_valid && !flush && (|w_src_stall);
        w_insert     = !hazard_stall && !flush;
    end

    // Advance the scoreboard and capture the selects into ID/EX timing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb         <= '0;
            r_ex_fwd_sel <= '0;
        end else if (!pipe_freeze) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                r_sb[k] <= r_sb[k-1];
            end
            r_sb[0]      <= w_insert ? w_id_entry : '0;
            r_ex_fwd_sel <= w_insert ? w_fwd_sel : '0;
        end
    end

    // Count unfrozen stall cycles, sticking at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (!pipe_freeze && hazard_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_fwd_sel = r_ex_fwd_sel;
    assign stall_cnt  = r_stall_cnt;

endmodule : fwd_hazard_scoreboard
`default_nettype wire

// File: tb/tb_fwd_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_scoreboard
// Brief    : Self-checking bench: directed vector table, multi-cycle
//            sequences on a deep/3-source instance, and randomized traffic
//            compared with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_scoreboard;

    localparam int c_DEPTH = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: DEPTH=3, NUM_SRC=2
    logic        reset, id_valid, id_reg_write, pipe_freeze, flush;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_rd;
    logic [1:0]  id_avail;
    logic        hazard_stall;
    logic [1:0]  id_wb_bypass;
    logic [3:0]  ex_fwd_sel;
    logic [31:0] stall_cnt;

    fwd_hazard_scoreboard #(.RA_W(5), .NUM_SRC(2), .DEPTH(3), .SW(2), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_avail(id_avail), .pipe_freeze(pipe_freeze), .flush(flush),
        .hazard_stall(hazard_stall), .id_wb_bypass(id_wb_bypass),
        .ex_fwd_sel(ex_fwd_sel), .stall_cnt(stall_cnt)
    );

    // Second instance: DEPTH=5, NUM_SRC=3, 2-bit counter to expose saturation
    logic        b_reset, b_valid, b_reg_write;
    logic [14:0] b_rs;
    logic [2:0]  b_used;
    logic [4:0]  b_rd;
    logic [2:0]  b_avail;
    logic        b_stall;
    logic [2:0]  b_bypass;
    logic [8:0]  b_sel;
    logic [1:0]  b_cnt;

    fwd_hazard_scoreboard #(.RA_W(5), .NUM_SRC(3), .DEPTH(5), .SW(3), .CNT_W(2)) u_dut5 (
        .clk(clk), .reset(b_reset), .id_valid(b_valid), .id_rs(b_rs),
        .id_rs_used(b_used), .id_rd(b_rd), .id_reg_write(b_reg_write),
        .id_avail(b_avail), .pipe_freeze(1'b0), .flush(1'b0),
        .hazard_stall(b_stall), .id_wb_bypass(b_bypass),
        .ex_fwd_sel(b_sel), .stall_cnt(b_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic       v;
        logic [4:0] rs0, rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] av;
        logic       frz, fl;
        logic       e_stall;
        logic [1:0] e_byp;
        logic [1:0] e_sel0, e_sel1;
        int         e_cnt;
    } vec_t;

    function automatic vec_t mk(int v, int rs0, int rs1, int used, int rd, int rw, int av,
                                int frz, int fl, int es, int eb, int s0, int s1, int cnt);
        vec_t r;
        r.v = 1'(v); r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.used = 2'(used);
        r.rd = 5'(rd); r.rw = 1'(rw); r.av = 2'(av); r.frz = 1'(frz); r.fl = 1'(fl);
        r.e_stall = 1'(es); r.e_byp = 2'(eb); r.e_sel0 = 2'(s0); r.e_sel1 = 2'(s1);
        r.e_cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw,
                         input logic [1:0] av, input logic frz, input logic fl);
        id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used; id_rd = rd;
        id_reg_write = rw; id_avail = av; pipe_freeze = frz; flush = fl;
    endtask

    task automatic drive_b(input logic v, input logic [14:0] rs, input logic [2:0] used,
                           input logic [4:0] rd, input logic rw, input logic [2:0] av);
        b_valid = v; b_rs = rs; b_used = used; b_rd = rd; b_reg_write = rw; b_avail = av;
    endtask

    // Reference model: in-flight writes ordered youngest first
    typedef struct { bit wen; int rd; int avail; } m_ent_t;
    m_ent_t mq[$];
    int     m_sel[2];
    longint m_cnt;

    task automatic model_reset();
        m_ent_t z;
        z.wen = 0; z.rd = 0; z.avail = 0;
        mq.delete();
        for (int j = 0; j < c_DEPTH; j++) mq.push_back(z);
        m_sel[0] = 0; m_sel[1] = 0; m_cnt = 0;
    endtask

    vec_t tbl[19];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] rsv[2];
        bit         st[2];
        int         sel[2];
        logic [1:0] e_byp;
        logic       e_stall;
        logic [3:0] e_sel;
        m_ent_t     ent;

        //                v rs0 rs1 us rd rw av fz fl | st byp s0 s1 cnt
        tbl[0]  = mk(1,  1,  2, 3,  5, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1,  5,  1, 3,  6, 1, 1, 0, 0,  0, 0, 1, 0, 0);
        tbl[2]  = mk(0,  0,  0, 0,  0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(1,  1,  0, 1,  5, 1, 2, 0, 0,  0, 0, 0, 0, 0);
        tbl[4]  = mk(1,  5,  5, 3,  7, 1, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[5]  = mk(1,  5,  5, 3,  7, 1, 1, 0, 0,  0, 0, 2, 2, 1);
        tbl[6]  = mk(1,  0,  0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[7]  = mk(1,  0,  0, 0,  3, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[8]  = mk(1,  3,  7, 3,  0, 1, 1, 0, 0,  0, 2, 1, 0, 1);
        tbl[9]  = mk(1,  0,  0, 3,  0, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[10] = mk(1,  0,  0, 0,  8, 1, 2, 0, 0,  0, 0, 0, 0, 1);
        tbl[11] = mk(1,  8,  0, 1,  9, 0, 1, 0, 1,  0, 0, 0, 0, 1);
        tbl[12] = mk(1,  8,  0, 1, 11, 1, 1, 0, 0,  0, 0, 2, 0, 1);
        tbl[13] = mk(1, 11,  0, 1, 10, 1, 2, 0, 0,  0, 0, 1, 0, 1);
        tbl[14] = mk(1,  0, 10, 2, 12, 1, 1, 1, 0,  1, 0, 1, 0, 1);
        tbl[15] = mk(1,  0, 10, 2, 12, 1, 1, 1, 0,  1, 0, 1, 0, 1);
        tbl[16] = mk(1,  0, 10, 2, 12, 1, 1, 1, 0,  1, 0, 1, 0, 1);
        tbl[17] = mk(1,  0, 10, 2, 12, 1, 1, 0, 0,  1, 0, 0, 0, 2);
        tbl[18] = mk(1,  0, 10, 2, 12, 1, 1, 0, 0,  0, 0, 0, 2, 2);

        reset = 1'b1; b_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        drive_b(0, 0, 0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall",  64'(hazard_stall), 0);
        chk("reset bypass", 64'(id_wb_bypass), 0);
        chk("reset sel",    64'(ex_fwd_sel),   0);
        chk("reset cnt",    64'(stall_cnt),    0);
        reset = 1'b0; b_reset = 1'b0;

        // Directed table on the main instance
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].v, tbl[i].rs0, tbl[i].rs1, tbl[i].used, tbl[i].rd,
                  tbl[i].rw, tbl[i].av, tbl[i].frz, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d stall", i),  64'(hazard_stall), 64'(tbl[i].e_stall));
            chk($sformatf("vec%0d bypass", i), 64'(id_wb_bypass), 64'(tbl[i].e_byp));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d sel0", i), 64'(ex_fwd_sel[1:0]), 64'(tbl[i].e_sel0));
            chk($sformatf("vec%0d sel1", i), 64'(ex_fwd_sel[3:2]), 64'(tbl[i].e_sel1));
            chk($sformatf("vec%0d cnt", i),  64'(stall_cnt),       64'(tbl[i].e_cnt));
        end

        // Deep instance: avail=4 producer forces a 3-cycle stall on source 2
        drive_b(1, 0, 0, 4, 1, 4);
        @(posedge clk); #1;
        drive_b(1, {5'd4, 5'd0, 5'd0}, 3'b100, 6, 1, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("deep stall c%0d", c), 64'(b_stall), 1);
            @(posedge clk); #1;
            chk($sformatf("deep cnt c%0d", c), 64'(b_cnt), 64'(c + 1));
            chk($sformatf("deep bubble sel c%0d", c), 64'(b_sel), 0);
        end
        @(negedge clk);
        chk("deep release stall", 64'(b_stall), 0);
        @(posedge clk); #1;
        chk("deep release sel", 64'(b_sel), 64'h100);

        // Saturated counter holds, then reset mid-stall clears everything
        drive_b(1, 0, 0, 4, 1, 4);
        @(posedge clk); #1;
        drive_b(1, {5'd4, 5'd0, 5'd0}, 3'b100, 6, 1, 1);
        @(negedge clk);
        chk("deep2 stall", 64'(b_stall), 1);
        @(posedge clk); #1;
        chk("deep cnt saturated", 64'(b_cnt), 3);
        b_reset = 1'b1;
        @(posedge clk); #1;
        chk("deep rst stall",  64'(b_stall),  0);
        chk("deep rst bypass", 64'(b_bypass), 0);
        chk("deep rst sel",    64'(b_sel),    0);
        chk("deep rst cnt",    64'(b_cnt),    0);
        b_reset = 1'b0;
        drive_b(0, 0, 0, 0, 0, 1);

        // Randomized traffic on the main instance against the model
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  2'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  2'($urandom_range(1, 2)), 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 9) == 0));
            rsv[0] = id_rs[4:0];
            rsv[1] = id_rs[9:5];
            e_byp  = '0;
            for (int i = 0; i < 2; i++) begin
                st[i] = 0; sel[i] = 0;
                if (id_rs_used[i] && rsv[i] != 0) begin
                    for (int j = 0; j < c_DEPTH; j++) begin
                        if (mq[j].wen && mq[j].rd == int'(rsv[i])) begin
                            // Producer moves to slot j+1 next cycle
                            if (j + 1 >= c_DEPTH)             e_byp[i] = 1'b1;
                            else if (mq[j].avail - (j + 1) > 0) st[i]   = 1;
                            else                              sel[i]   = j + 1;
                            break;
                        end
                    end
                end
            end
            e_stall = id_valid && !flush && (st[0] || st[1]);
            @(negedge clk);
            chk($sformatf("rnd%0d stall", n),  64'(hazard_stall), 64'(e_stall));
            chk($sformatf("rnd%0d bypass", n), 64'(id_wb_bypass), 64'(e_byp));
            @(posedge clk); #1;
            if (!pipe_freeze) begin
                ent.wen   = id_valid && id_reg_write && id_rd != 0;
                ent.rd    = int'(id_rd);
                ent.avail = int'(id_avail);
                if (e_stall || flush) begin
                    ent.wen = 0;
                    m_sel[0] = 0; m_sel[1] = 0;
                end else begin
                    m_sel[0] = sel[0]; m_sel[1] = sel[1];
                end
                mq.push_front(ent);
                void'(mq.pop_back());
                if (e_stall) m_cnt++;
            end
            e_sel = {2'(m_sel[1]), 2'(m_sel[0])};
            chk($sformatf("rnd%0d sel", n), 64'(ex_fwd_sel), 64'(e_sel));
            chk($sformatf("rnd%0d cnt", n), 64'(stall_cnt),  64'(m_cnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_fwd_hazard_scoreboard
`default_nettype wire
